// File: rtl/tour_length_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tour_length_if : start/result handshake, point RAM port, distance pair   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface tour_length_if #(parameter int AW = 4);
  logic          start;
  logic [AW:0]   n_city;
  logic [AW-1:0] pt_addr;
  logic [7:0]    pt_x;
  logic [7:0]    pt_y;
  logic [7:0]    x1;
  logic [7:0]    y1;
  logic [7:0]    x2;
  logic [7:0]    y2;
  logic [31:0]   dist_res;
  logic [31:0]   total;
  logic          busy;
  logic          done;

  modport slave (
    input  start, n_city, pt_x, pt_y, dist_res,
    output pt_addr, x1, y1, x2, y2, total, busy, done
  );

  modport master (
    output start, n_city, pt_x, pt_y, dist_res,
    input  pt_addr, x1, y1, x2, y2, total, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/tour_length.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tour_length : walks a closed tour, feeds point pairs, sums distances     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tour_length #(
  parameter int N_MAX = 16,
  parameter int LAT   = 11,
  parameter int AW    = $clog2(N_MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  tour_length_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CLOSE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW:0]    N_CAP   = (AW+1)'(N_MAX);
  localparam logic [LAT-1:0] TOP_BIT = {1'b1, {(LAT-1){1'b0}}};

  logic [2:0]     state;
  logic [AW:0]    n_lat;
  logic           addr_vld;
  logic           rd_vld;
  logic [AW-1:0]  rd_k;
  logic [7:0]     first_x;
  logic [7:0]     first_y;
  logic [7:0]     prev_x;
  logic [7:0]     prev_y;
  logic           pair_vld;
  logic [LAT-1:0] vline;

  logic [AW:0] n_clamped;
  logic [AW:0] last_idx;
  logic        drain_last;

  assign n_clamped = (bus.n_city > N_CAP) ? N_CAP : bus.n_city;
  assign last_idx  = n_lat - (AW+1)'(1);
  // Only the final result may still be in flight: it is added on this edge.
  assign drain_last = !pair_vld && ((vline & ~TOP_BIT) == '0);
  assign bus.done   = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      n_lat    <= '0;
      addr_vld <= 1'b0;
      rd_vld   <= 1'b0;
      rd_k     <= '0;
      first_x  <= '0;
      first_y  <= '0;
      prev_x   <= '0;
      prev_y   <= '0;
      pair_vld <= 1'b0;
      vline    <= '0;
      bus.pt_addr <= '0;
      bus.x1      <= '0;
      bus.y1      <= '0;
      bus.x2      <= '0;
      bus.y2      <= '0;
      bus.total   <= '0;
      bus.busy    <= 1'b0;
    end else begin
      pair_vld <= 1'b0;
      // pair_vld marks a pair on the bus; vline[LAT-1] lines up with its result.
      vline    <= {vline[LAT-2:0], pair_vld};
      if (vline[LAT-1])
        bus.total <= bus.total + bus.dist_res;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            n_lat     <= n_clamped;
            bus.total <= '0;
            if (n_clamped < (AW+1)'(2)) begin
              state <= S_DONE;
            end else begin
              state       <= S_FETCH;
              bus.pt_addr <= '0;
              addr_vld    <= 1'b1;
              rd_vld      <= 1'b0;
              bus.busy    <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          rd_vld <= addr_vld;
          rd_k   <= bus.pt_addr;
          if (addr_vld) begin
            if ({1'b0, bus.pt_addr} == last_idx)
              addr_vld <= 1'b0;
            else
              bus.pt_addr <= bus.pt_addr + AW'(1);
          end
          if (rd_vld) begin
            prev_x <= bus.pt_x;
            prev_y <= bus.pt_y;
            if (rd_k == '0) begin
              first_x <= bus.pt_x;
              first_y <= bus.pt_y;
            end else begin
              bus.x1   <= prev_x;
              bus.y1   <= prev_y;
              bus.x2   <= bus.pt_x;
              bus.y2   <= bus.pt_y;
              pair_vld <= 1'b1;
            end
            if ({1'b0, rd_k} == last_idx)
              state <= S_CLOSE;
          end
        end

        S_CLOSE: begin
          bus.x1   <= prev_x;
          bus.y1   <= prev_y;
          bus.x2   <= first_x;
          bus.y2   <= first_y;
          pair_vld <= 1'b1;
          state    <= S_DRAIN;
        end

        S_DRAIN: begin
          if (drain_last) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
          end
        end

        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tour_length.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tour_length : directed and random tours against a tour-length model   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_tour_length;
  localparam int N_MAX = 16;
  localparam int LAT   = 11;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tour_length_if #(.AW(AW)) bif ();

  tour_length #(.N_MAX(N_MAX), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  logic [7:0]  mem_x [N_MAX];
  logic [7:0]  mem_y [N_MAX];
  logic [31:0] pipe  [LAT];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int unsigned isqrt(input int unsigned v);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int unsigned edge_len(input int ax, input int ay, input int bx, input int by);
    int dx = ax - bx;
    int dy = ay - by;
    return isqrt(dx * dx + dy * dy);
  endfunction

  // Sync-read point RAM and a fixed-latency distance pipeline around the DUT.
  always @(posedge clk) begin
    bif.pt_x <= mem_x[bif.pt_addr];
    bif.pt_y <= mem_y[bif.pt_addr];
  end

  always @(posedge clk) begin
    pipe[0] <= edge_len(int'(bif.x1), int'(bif.y1), int'(bif.x2), int'(bif.y2));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bif.dist_res = pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: closed-tour sum of floor distances, pairs in tour order, done after n+3+LAT edges.
  task automatic run_tour(input int n_in, input bit restart);
    int n, exp_done, done_cnt, done_at, k, a, b;
    int unsigned exp_total;
    n = (n_in > N_MAX) ? N_MAX : n_in;
    exp_total = 0;
    if (n >= 2)
      for (int i = 0; i < n; i++)
        exp_total += edge_len(int'(mem_x[i]), int'(mem_y[i]),
                              int'(mem_x[(i+1)%n]), int'(mem_y[(i+1)%n]));
    exp_done = (n >= 2) ? n + 3 + LAT : 0;
    done_cnt = 0;
    done_at  = -1;
    bif.n_city = (AW+1)'(n_in);
    bif.start  = 1'b1;
    tick();
    bif.start = 1'b0;
    for (int j = 0; j <= exp_done + 4; j++) begin
      if (j > 0) tick();
      if (restart && j == 2) begin
        bif.start  = 1'b1;
        bif.n_city = (AW+1)'((n == N_MAX) ? 3 : N_MAX);
      end else begin
        bif.start = 1'b0;
      end
      if (bif.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
        check("total_at_done", bif.total, exp_total);
      end
      if (n >= 2) begin
        check("busy", {31'd0, bif.busy}, {31'd0, (j < exp_done)});
        if (j >= 3 && j <= n + 2) begin
          k = j - 2;
          a = k - 1;
          b = (k == n) ? 0 : k;
          check("pair", {bif.x1, bif.y1, bif.x2, bif.y2},
                {mem_x[a], mem_y[a], mem_x[b], mem_y[b]});
        end
      end
    end
    check("done_count", done_cnt, 1);
    check("done_edge", done_at, exp_done);
    check("total_hold", bif.total, exp_total);
  endtask

  task automatic set_pt(input int i, input int x, input int y);
    mem_x[i] = 8'(x);
    mem_y[i] = 8'(y);
  endtask

  task automatic rand_points();
    for (int i = 0; i < N_MAX; i++) set_pt(i, $urandom_range(255), $urandom_range(255));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pt_addr"}, {28'd0, bif.pt_addr}, 32'd0);
    check({tag, "_pair"}, {bif.x1, bif.y1, bif.x2, bif.y2}, 32'd0);
    check({tag, "_total"}, bif.total, 32'd0);
    check({tag, "_busy_done"}, {30'd0, bif.busy, bif.done}, 32'd0);
  endtask

  initial begin
    int bad_done;
    bif.start  = 1'b0;
    bif.n_city = '0;
    for (int i = 0; i < N_MAX; i++) set_pt(i, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    check_cleared("reset");

    set_pt(0, 0, 0); set_pt(1, 3, 4); set_pt(2, 6, 0);
    run_tour(3, 1'b0);

    set_pt(0, 0, 0); set_pt(1, 6, 8);
    run_tour(2, 1'b0);
    run_tour(1, 1'b0);
    run_tour(0, 1'b0);

    for (int i = 0; i < N_MAX; i++) set_pt(i, 255, 255);
    set_pt(0, 0, 0);
    run_tour(16, 1'b0);

    rand_points();
    run_tour(10, 1'b1);

    for (int r = 0; r < 5; r++) begin
      rand_points();
      run_tour($urandom_range(2, N_MAX), 1'b0);
    end
    rand_points();
    run_tour(N_MAX + 4, 1'b0);

    // Reset during DRAIN: in-flight results must be dropped.
    set_pt(0, 0, 0); set_pt(1, 3, 4); set_pt(2, 6, 0);
    bif.n_city = (AW+1)'(3);
    bif.start  = 1'b1;
    tick();
    bif.start = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_cleared("mid_reset");
    bad_done = 0;
    for (int j = 0; j < LAT + 6; j++) begin
      tick();
      if (bif.done !== 1'b0) bad_done++;
    end
    check("no_done_after_reset", bad_done, 0);
    check("total_after_reset", bif.total, 32'd0);

    set_pt(0, 0, 0); set_pt(1, 6, 8);
    run_tour(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
